// File: rtl/div_seq.sv
// Multicycle signed restoring divider: one quotient bit per cycle, MIPS div semantics.
// Quotient on LO, remainder on HI; DivStop/DivZero are single-cycle registered pulses.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DivCtrl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              DivZero,
  output logic              DivStop,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE       = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO      = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rem_r, quot_r, dvsr_r;
  logic              sign_q_r, sign_r_r;
  logic [DATA_W-1:0] hi_r, lo_r;
  logic              div_zero_r, div_stop_r;
  logic              b_nonzero_s;
  logic [DATA_W:0]   shifted_s, diff_s;

  // Two's complement negate; -MIN wraps back to MIN, which gives the MIPS overflow result.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + ONE;
  endfunction

  // Magnitude as an unsigned value, so MIN maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? negate(x) : x;
  endfunction

  assign b_nonzero_s = |B;
  assign shifted_s   = {rem_r, quot_r[DATA_W-1]};
  assign diff_s      = shifted_s - {1'b0, dvsr_r};

  assign DivZero = div_zero_r;
  assign DivStop = div_stop_r;
  assign HI      = hi_r;
  assign LO      = lo_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (DivCtrl && b_nonzero_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_ITER) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result/pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= {CNT_W{1'b0}};
      rem_r      <= ZERO;
      quot_r     <= ZERO;
      dvsr_r     <= ZERO;
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      hi_r       <= ZERO;
      lo_r       <= ZERO;
      div_zero_r <= 1'b0;
      div_stop_r <= 1'b0;
    end else begin
      div_zero_r <= 1'b0;
      div_stop_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (DivCtrl && !b_nonzero_s) begin
            div_zero_r <= 1'b1;
          end else if (DivCtrl) begin
            quot_r   <= magnitude(A);
            dvsr_r   <= magnitude(B);
            rem_r    <= ZERO;
            sign_q_r <= A[DATA_W-1] ^ B[DATA_W-1];
            sign_r_r <= A[DATA_W-1];
            cnt_r    <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_RUN: begin
          // diff_s MSB set means the trial subtraction went negative: keep the shifted remainder.
          rem_r  <= diff_s[DATA_W] ? shifted_s[DATA_W-1:0] : diff_s[DATA_W-1:0];
          quot_r <= {quot_r[DATA_W-2:0], ~diff_s[DATA_W]};
          cnt_r  <= cnt_r + CNT_ONE;
        end
        ST_DONE: begin
          lo_r       <= sign_q_r ? negate(quot_r) : quot_r;
          hi_r       <= sign_r_r ? negate(rem_r) : rem_r;
          div_stop_r <= 1'b1;
        end
        default: begin
          div_zero_r <= 1'b0;
          div_stop_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, hand-written corner sequences,
// and random operands checked against a plain signed-arithmetic reference.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         DivCtrl;
  logic [W-1:0] A, B;
  logic         DivZero, DivStop;
  logic [W-1:0] HI, LO;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .DivCtrl(DivCtrl),
    .A      (A),
    .B      (B),
    .DivZero(DivZero),
    .DivStop(DivStop),
    .HI     (HI),
    .LO     (LO)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: truncating signed division in 64-bit arithmetic, remainder follows dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[W-1:0];
    r  = lr[W-1:0];
  endfunction

  // Starts a division at the next edge (E0) and expects the result exactly 33 edges later.
  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                         input bit busy);
    logic [W-1:0] hold_hi, hold_lo;
    int  got;
    bit  mid_change, spurious;
    hold_hi    = HI;
    hold_lo    = LO;
    got        = 0;
    mid_change = 1'b0;
    spurious   = 1'b0;
    A = a;
    B = b;
    DivCtrl = 1'b1;
    @(posedge clk); #1;
    DivCtrl = 1'b0;
    if (DivZero || DivStop) spurious = 1'b1;
    if (HI !== hold_hi || LO !== hold_lo) mid_change = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (busy && k == 4) A = 32'h1234_5678;
      if (busy && k == 9) begin
        DivCtrl = 1'b1;
        B = 32'h0000_0000;
      end
      if (busy && k == 10) DivCtrl = 1'b0;
      @(posedge clk); #1;
      if (DivZero) spurious = 1'b1;
      if (DivStop) begin
        got = k;
        break;
      end
      if (HI !== hold_hi || LO !== hold_lo) mid_change = 1'b1;
    end
    check({name, " latency"}, W'(got), 32'd33);
    check({name, " LO"}, LO, exp_lo);
    check({name, " HI"}, HI, exp_hi);
    check({name, " held mid-run"}, {31'd0, mid_change}, 32'd0);
    check({name, " stray pulse"}, {31'd0, spurious}, 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] ra, rb, rq, rr;
    int  stop_seen, zero_cnt;
    bit  held;

    vecs.push_back('{32'd7,         32'd2,         32'd3,         32'd1});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back('{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
    vecs.push_back('{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0});
    vecs.push_back('{32'd0,         32'd5,         32'd0,         32'd0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'h7FFF_FFFF});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{32'd7,         32'd2,         32'd3,         32'd1});

    reset   = 1'b1;
    DivCtrl = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
    #2;
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset DivZero", {31'd0, DivZero}, 32'd0);
    check("reset DivStop", {31'd0, DivStop}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi, 1'b0);
    end

    // Divide by zero with HI/LO preloaded to 1/3 by the last vector.
    A = 32'd5;
    B = 32'd0;
    DivCtrl = 1'b1;
    @(posedge clk); #1;
    DivCtrl = 1'b0;
    check("dz DivZero", {31'd0, DivZero}, 32'd1);
    check("dz DivStop", {31'd0, DivStop}, 32'd0);
    stop_seen = 0;
    zero_cnt  = 1;
    held      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (DivStop) stop_seen++;
      if (DivZero) zero_cnt++;
      if (HI !== 32'd1 || LO !== 32'd3) held = 1'b0;
    end
    check("dz no DivStop", W'(stop_seen), 32'd0);
    check("dz pulse count", W'(zero_cnt), 32'd1);
    check("dz HI/LO held", {31'd0, held}, 32'd1);

    // Zero divisor at E0, then a valid start accepted right at E1.
    A = 32'd5;
    B = 32'd0;
    DivCtrl = 1'b1;
    @(posedge clk); #1;
    check("dz2 DivZero", {31'd0, DivZero}, 32'd1);
    run_div("dz restart", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);

    run_div("busy", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

    // Reset asserted mid-run.
    A = 32'd1000;
    B = 32'd3;
    DivCtrl = 1'b1;
    @(posedge clk); #1;
    DivCtrl = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst HI", HI, 32'd0);
    check("midrst LO", LO, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    stop_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (DivStop || DivZero) stop_seen++;
    end
    check("midrst no pulse", W'(stop_seen), 32'd0);
    run_div("after reset", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
      if (i % 6 == 0) rb = ~rb + 32'd1;
      if (i % 5 == 0) ra = 32'($urandom_range(0, 100));
      if (rb == 32'd0) rb = 32'd1;
      ref_div(ra, rb, rq, rr);
      run_div($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, rq, rr, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
